// File: rtl/pcpi_pkg.sv
// pcpi_pkg
// Shared definitions for the PCPI multiply/divide co-processors:
// RV32M opcode/funct7/funct3 constants, the common handshake state
// encoding, and small operand-conditioning helpers.
package pcpi_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_HOLD = 2'b11
    } pcpi_state_t;

    // Two's-complement magnitude of a value whose sign is already known.
    // 0x8000_0000 maps to itself, which is the correct unsigned 2^31.
    function automatic logic [31:0] op_magnitude(input logic [31:0] value,
                                                 input logic        is_neg);
        op_magnitude = is_neg ? (32'd0 - value) : value;
    endfunction

    // Zero the low n bits of a 32-bit operand.
    function automatic logic [31:0] drop_low_bits(input logic [31:0] value,
                                                  input logic [4:0]  n);
        drop_low_bits = value & (32'hFFFF_FFFF << n);
    endfunction

endpackage

// File: rtl/pcpi_mul_decode.sv
// pcpi_mul_decode
// Combinational decode of RV32M multiply instructions.
// Ports:
//   insn        - instruction word
//   match       - word is MUL/MULH/MULHSU/MULHU
//   op_high     - result is the upper product word
//   rs1_signed  - rs1 is interpreted as signed
//   rs2_signed  - rs2 is interpreted as signed
module pcpi_mul_decode
    import pcpi_pkg::*;
(
    input  logic [31:0] insn,
    output logic        match,
    output logic        op_high,
    output logic        rs1_signed,
    output logic        rs2_signed
);

    // Register-index fields play no part in decode.
    logic unused_fields;
    assign unused_fields = ^{insn[24:15], insn[11:7]};

    // Opcode/funct7 gate, then funct3 selects the multiply flavour.
    always_comb begin
        match      = 1'b0;
        op_high    = 1'b0;
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        if ((insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV)) begin
            case (insn[14:12])
                FUNCT3_MUL: begin
                    match = 1'b1;
                end
                FUNCT3_MULH: begin
                    match      = 1'b1;
                    op_high    = 1'b1;
                    rs1_signed = 1'b1;
                    rs2_signed = 1'b1;
                end
                FUNCT3_MULHSU: begin
                    match      = 1'b1;
                    op_high    = 1'b1;
                    rs1_signed = 1'b1;
                end
                FUNCT3_MULHU: begin
                    match   = 1'b1;
                    op_high = 1'b1;
                end
                default: begin
                    match = 1'b0;
                end
            endcase
        end else begin
            match = 1'b0;
        end
    end

endmodule

// File: rtl/pcpi_approx_mul.sv
// pcpi_approx_mul
// PCPI multiplier with optional operand truncation: the low N bits of each
// operand magnitude are dropped, and the radix-2 shift-add loop skips the
// corresponding multiplier bits, so latency shrinks to 33-N cycles.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   pcpi_valid/insn/rs1/rs2 - PCPI request from the core
//   approx_level          - N, low bits dropped (ignored if ENABLE_APPROX=0)
//   pcpi_wr/rd/wait/ready - PCPI response (all registered)
module pcpi_approx_mul
    import pcpi_pkg::*;
#(
    parameter bit ENABLE_APPROX = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    input  logic [4:0]  approx_level,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    pcpi_state_t state_r;
    pcpi_state_t next_state_s;

    logic        dec_match_s;
    logic        dec_op_high_s;
    logic        dec_rs1_signed_s;
    logic        dec_rs2_signed_s;

    logic [4:0]  n_eff_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;

    logic [63:0] acc_r;
    logic [63:0] mcand_r;
    logic [31:0] mplier_r;
    logic [5:0]  cnt_r;
    logic        neg_r;
    logic        op_high_r;

    logic [63:0] acc_next_s;
    logic [63:0] prod_s;
    logic [31:0] result_s;

    pcpi_mul_decode u_decode (
        .insn       (pcpi_insn),
        .match      (dec_match_s),
        .op_high    (dec_op_high_s),
        .rs1_signed (dec_rs1_signed_s),
        .rs2_signed (dec_rs2_signed_s)
    );

    // Operand conditioning at accept: sign strip, then truncation.
    always_comb begin
        n_eff_s = ENABLE_APPROX ? approx_level : 5'd0;
        a_neg_s = dec_rs1_signed_s & pcpi_rs1[31];
        b_neg_s = dec_rs2_signed_s & pcpi_rs2[31];
        a_mag_s = drop_low_bits(op_magnitude(pcpi_rs1, a_neg_s), n_eff_s);
        b_mag_s = drop_low_bits(op_magnitude(pcpi_rs2, b_neg_s), n_eff_s);
    end

    // One shift-add step, plus sign fix-up and word select of the final sum.
    always_comb begin
        acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        prod_s     = neg_r ? (64'd0 - acc_next_s) : acc_next_s;
        result_s   = op_high_r ? prod_s[63:32] : prod_s[31:0];
    end

    // Handshake next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pcpi_valid && dec_match_s) begin
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A withdrawn request aborts even on the final step.
                if (!pcpi_valid) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r == 6'd31) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                next_state_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (!pcpi_valid) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered PCPI outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            acc_r      <= 64'd0;
            mcand_r    <= 64'd0;
            mplier_r   <= 32'd0;
            cnt_r      <= 6'd0;
            neg_r      <= 1'b0;
            op_high_r  <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= 32'd0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ST_IDLE: begin
                    if (next_state_s == ST_BUSY) begin
                        // Pre-align both operands to multiplier bit N.
                        acc_r     <= 64'd0;
                        mcand_r   <= {32'd0, a_mag_s} << n_eff_s;
                        mplier_r  <= b_mag_s >> n_eff_s;
                        cnt_r     <= {1'b0, n_eff_s};
                        neg_r     <= a_neg_s ^ b_neg_s;
                        op_high_r <= dec_op_high_s;
                    end
                end
                ST_BUSY: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + 6'd1;
                end
                default: begin
                end
            endcase
            pcpi_wait  <= (next_state_s == ST_BUSY);
            pcpi_ready <= (next_state_s == ST_DONE);
            pcpi_wr    <= (next_state_s == ST_DONE);
            pcpi_rd    <= (next_state_s == ST_DONE) ? result_s : 32'd0;
        end
    end

endmodule

// File: tb/tb_pcpi_approx_mul.sv
// Self-checking bench for pcpi_approx_mul: a table of directed vectors
// applied to two instances (approximation enabled / disabled), plus
// hand-written sequences for decode rejection, abort and mid-op reset.
module tb_pcpi_approx_mul;

    localparam logic [31:0] I_MUL    = 32'h0200_02B3;
    localparam logic [31:0] I_MULH   = 32'h0200_12B3;
    localparam logic [31:0] I_MULHSU = 32'h0200_22B3;
    localparam logic [31:0] I_MULHU  = 32'h0200_32B3;
    localparam logic [31:0] I_DIV    = 32'h0200_42B3;
    localparam logic [31:0] I_ADD    = 32'h0000_02B3;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  n;
        logic [31:0] exp_rd;
        int          exp_cyc;
        logic [31:0] exp_rd0;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic [4:0]  approx_level;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;
    logic        pcpi_wr_0, pcpi_wait_0, pcpi_ready_0;
    logic [31:0] pcpi_rd_0;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[11];

    always #5 clk = ~clk;

    pcpi_approx_mul dut (
        .clk          (clk),
        .reset        (reset),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_rs1     (pcpi_rs1),
        .pcpi_rs2     (pcpi_rs2),
        .approx_level (approx_level),
        .pcpi_wr      (pcpi_wr),
        .pcpi_rd      (pcpi_rd),
        .pcpi_wait    (pcpi_wait),
        .pcpi_ready   (pcpi_ready)
    );

    pcpi_approx_mul #(.ENABLE_APPROX(1'b0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_rs1     (pcpi_rs1),
        .pcpi_rs2     (pcpi_rs2),
        .approx_level (approx_level),
        .pcpi_wr      (pcpi_wr_0),
        .pcpi_rd      (pcpi_rd_0),
        .pcpi_wait    (pcpi_wait_0),
        .pcpi_ready   (pcpi_ready_0)
    );

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Issue one request in a fresh cycle 0, observe cycles 1..40 with valid
    // held (so HOLD is exercised), then release valid.
    task automatic run_vec(input vec_t v, input int idx);
        int first1 = 0, first0 = 0, cnt1 = 0, cnt0 = 0;
        int wcnt1 = 0, wcnt0 = 0, perr = 0;
        logic [31:0] rd1 = 32'd0, rd0 = 32'd0;
        @(posedge clk); #1;
        pcpi_insn = v.insn; pcpi_rs1 = v.rs1; pcpi_rs2 = v.rs2;
        approx_level = v.n; pcpi_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); @(negedge clk);
            if (pcpi_ready) begin
                if (cnt1 == 0) begin first1 = c; rd1 = pcpi_rd; end
                cnt1++;
            end
            if (pcpi_ready_0) begin
                if (cnt0 == 0) begin first0 = c; rd0 = pcpi_rd_0; end
                cnt0++;
            end
            if (pcpi_wait)   wcnt1++;
            if (pcpi_wait_0) wcnt0++;
            if ((pcpi_wr !== pcpi_ready) || (!pcpi_ready && pcpi_rd !== 32'd0)) perr++;
            if ((pcpi_wr_0 !== pcpi_ready_0) || (!pcpi_ready_0 && pcpi_rd_0 !== 32'd0)) perr++;
            // Level changes after accept must not disturb the operation.
            if (c == 2) approx_level = ~v.n;
        end
        @(posedge clk); #1;
        pcpi_valid = 1'b0;
        repeat (2) @(posedge clk);
        check("rd",           idx, {32'd0, rd1}, {32'd0, v.exp_rd});
        check("ready_cycle",  idx, 64'(first1), 64'(v.exp_cyc));
        check("ready_count",  idx, 64'(cnt1), 64'd1);
        check("wait_cycles",  idx, 64'(wcnt1), 64'(v.exp_cyc - 1));
        check("rd_noapx",     idx, {32'd0, rd0}, {32'd0, v.exp_rd0});
        check("ready_cycle_noapx", idx, 64'(first0), 64'd33);
        check("ready_count_noapx", idx, 64'(cnt0), 64'd1);
        check("wait_cycles_noapx", idx, 64'(wcnt0), 64'd32);
        check("wr_rd_protocol",    idx, 64'(perr), 64'd0);
    endtask

    initial begin
        int bad;
        int rdy;
        vec_t v;

        //             insn      rs1            rs2            N      rd             cyc  rd(no approx)
        vecs[0]  = '{I_MUL,    32'd7,         32'd6,         5'd0,  32'd42,        33,  32'd42};
        vecs[1]  = '{I_MULH,   32'hFFFF_FFFF, 32'd2,         5'd0,  32'hFFFF_FFFF, 33,  32'hFFFF_FFFF};
        vecs[2]  = '{I_MULHU,  32'hFFFF_FFFF, 32'd2,         5'd0,  32'h0000_0001, 33,  32'h0000_0001};
        vecs[3]  = '{I_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd0,  32'hFFFF_FFFF, 33,  32'hFFFF_FFFF};
        vecs[4]  = '{I_MUL,    32'h13,        32'h25,        5'd4,  32'h200,       29,  32'h2BF};
        vecs[5]  = '{I_MUL,    32'hFFFF_FFFD, 32'd5,         5'd0,  32'hFFFF_FFF1, 33,  32'hFFFF_FFF1};
        vecs[6]  = '{I_MULH,   32'h8000_0000, 32'h8000_0000, 5'd0,  32'h4000_0000, 33,  32'h4000_0000};
        vecs[7]  = '{I_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE, 33,  32'hFFFF_FFFE};
        vecs[8]  = '{I_MULH,   32'h8000_0000, 32'h8000_0000, 5'd31, 32'h4000_0000, 2,   32'h4000_0000};
        vecs[9]  = '{I_MULHU,  32'h1234_5678, 32'h0000_01FF, 5'd8,  32'h0000_0012, 25,  32'h0000_0024};
        vecs[10] = '{I_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE, 33,  32'hFFFF_FFFE};

        reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = 32'd0;
        pcpi_rs1 = 32'd0; pcpi_rs2 = 32'd0; approx_level = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_wr",    0, 64'(pcpi_wr),    64'd0);
        check("reset_rd",    0, 64'(pcpi_rd),    64'd0);
        check("reset_wait",  0, 64'(pcpi_wait),  64'd0);
        check("reset_ready", 0, 64'(pcpi_ready), 64'd0);
        check("reset_wr_noapx",    0, 64'(pcpi_wr_0),    64'd0);
        check("reset_rd_noapx",    0, 64'(pcpi_rd_0),    64'd0);
        check("reset_wait_noapx",  0, 64'(pcpi_wait_0),  64'd0);
        check("reset_ready_noapx", 0, 64'(pcpi_ready_0), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // Non-multiply words are never claimed.
        bad = 0;
        @(posedge clk); #1;
        pcpi_insn = I_DIV; pcpi_rs1 = 32'd100; pcpi_rs2 = 32'd7; pcpi_valid = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); @(negedge clk);
            if (pcpi_wait || pcpi_ready || pcpi_wr || pcpi_wait_0 || pcpi_ready_0 || pcpi_wr_0) bad++;
            if (c == 32) pcpi_insn = I_ADD;
        end
        check("nonmatch_quiet", 0, 64'(bad), 64'd0);
        @(posedge clk); #1; pcpi_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Abort: valid withdrawn in cycle 10 of a busy operation.
        rdy = 0;
        @(posedge clk); #1;
        pcpi_insn = I_MUL; pcpi_rs1 = 32'h13; pcpi_rs2 = 32'h25;
        approx_level = 5'd0; pcpi_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); @(negedge clk);
            if (pcpi_ready || pcpi_ready_0) rdy++;
            if (c == 10) begin
                check("abort_busy_wait", 10, 64'(pcpi_wait), 64'd1);
                pcpi_valid = 1'b0;
            end
            if (c == 11) check("abort_wait_cleared", 11, 64'(pcpi_wait), 64'd0);
        end
        check("abort_no_ready", 0, 64'(rdy), 64'd0);
        v = '{I_MUL, 32'd3, 32'd5, 5'd0, 32'd15, 33, 32'd15};
        run_vec(v, 100);

        // Reset during BUSY wins; nothing completes afterwards.
        rdy = 0;
        @(posedge clk); #1;
        pcpi_insn = I_MUL; pcpi_rs1 = 32'd9; pcpi_rs2 = 32'd9;
        approx_level = 5'd0; pcpi_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); @(negedge clk);
        end
        check("pre_reset_wait", 20, 64'(pcpi_wait), 64'd1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midreset_wr",    21, 64'(pcpi_wr),    64'd0);
        check("midreset_rd",    21, 64'(pcpi_rd),    64'd0);
        check("midreset_wait",  21, 64'(pcpi_wait),  64'd0);
        check("midreset_ready", 21, 64'(pcpi_ready), 64'd0);
        reset = 1'b0; pcpi_valid = 1'b0;
        for (int c = 22; c <= 50; c++) begin
            @(posedge clk); @(negedge clk);
            if (pcpi_ready || pcpi_wait || pcpi_ready_0 || pcpi_wait_0) rdy++;
        end
        check("post_reset_quiet", 0, 64'(rdy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
